// File: rtl/depar_pkg.sv
// Shared deparser definitions: state encoding, AXIS segment bundle, drop bit.
package depar_pkg;

    localparam int unsigned AXIS_DW = 512;
    localparam int unsigned AXIS_UW = 128;
    localparam int unsigned AXIS_KW = AXIS_DW / 8;

    // Default tuser bit in segment 1 that marks a packet for discard
    localparam int unsigned DROP_BIT_DFLT = 0;

    localparam logic [1:0] ST_WAIT_FST  = 2'd0;
    localparam logic [1:0] ST_EMIT_SND  = 2'd1;
    localparam logic [1:0] ST_FLUSH_SEG = 2'd2;

    typedef enum logic [1:0] {
        WAIT_FST  = ST_WAIT_FST,
        EMIT_SND  = ST_EMIT_SND,
        FLUSH_SEG = ST_FLUSH_SEG
    } state_t;

    // One AXIS segment beat at the default deparser widths
    typedef struct packed {
        logic [AXIS_DW-1:0] tdata;
        logic [AXIS_UW-1:0] tuser;
        logic [AXIS_KW-1:0] tkeep;
        logic               tlast;
    } seg_t;

endpackage

// File: rtl/depar_axis_out_reg.sv
// Registered AXI-Stream output stage: loads one beat when asked, holds it
// stable under backpressure, and reports when a new beat may be loaded.
module depar_axis_out_reg
    import depar_pkg::*;
#(
    parameter int unsigned DATA_W = AXIS_DW,
    parameter int unsigned USER_W = AXIS_UW
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  load,
    input  logic [DATA_W-1:0]     load_tdata,
    input  logic [USER_W-1:0]     load_tuser,
    input  logic [DATA_W/8-1:0]   load_tkeep,
    input  logic                  load_tlast,
    output logic                  out_ok_c,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [USER_W-1:0]     m_axis_tuser,
    output logic [DATA_W/8-1:0]   m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int unsigned KEEP_W = DATA_W / 8;

    // Register may take a new beat when empty or when its beat leaves this cycle
    assign out_ok_c = !m_axis_tvalid || m_axis_tready;

    // Output register: load on request, drop valid once drained, else hold
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tkeep  <= KEEP_W'(0);
            m_axis_tlast  <= 1'b0;
            m_axis_tvalid <= 1'b0;
        end else if (load) begin
            m_axis_tdata  <= load_tdata;
            m_axis_tuser  <= load_tuser;
            m_axis_tkeep  <= load_tkeep;
            m_axis_tlast  <= load_tlast;
            m_axis_tvalid <= 1'b1;
        end else if (out_ok_c) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/depar_seg_merge.sv
// Deparser output stage: reassembles packets from the first-half, second-half
// and remaining-segment FIFOs onto one AXI-Stream master.
// Optional packet discard is enabled by defining DEPAR_SEG_MERGE_DROP_EN.
module depar_seg_merge
    import depar_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH  = AXIS_DW,
    parameter int unsigned C_AXIS_TUSER_WIDTH = AXIS_UW,
    parameter int unsigned C_DROP_BIT         = DROP_BIT_DFLT
) (
    input  logic                              clk,
    input  logic                              aresetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      fst_half_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     fst_half_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    fst_half_tkeep,
    input  logic                              fst_half_tlast,
    input  logic                              fst_half_empty,
    output logic                              fst_half_rd_en,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      snd_half_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     snd_half_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    snd_half_tkeep,
    input  logic                              snd_half_tlast,
    input  logic                              snd_half_empty,
    output logic                              snd_half_rd_en,

    input  logic [C_AXIS_DATA_WIDTH-1:0]      seg_fifo_tdata,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     seg_fifo_tuser,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    seg_fifo_tkeep,
    input  logic                              seg_fifo_tlast,
    input  logic                              seg_fifo_empty,
    output logic                              seg_fifo_rd_en,

    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready
);

    localparam int unsigned KEEP_W = C_AXIS_DATA_WIDTH / 8;

`ifdef DEPAR_SEG_MERGE_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    state_t state_q;
    state_t state_d;
    logic   drop_q;
    logic   drop_d;
    logic   drop_fst_c;
    logic   out_ok_c;

    logic                          load;
    logic [C_AXIS_DATA_WIDTH-1:0]  ld_tdata;
    logic [C_AXIS_TUSER_WIDTH-1:0] ld_tuser;
    logic [KEEP_W-1:0]             ld_tkeep;
    logic                          ld_tlast;

    // Discard request carried by the head of the first-half FIFO
    assign drop_fst_c = DROP_EN && fst_half_tuser[C_DROP_BIT];

    // State and packet-drop flag registers
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_q <= WAIT_FST;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    // Next state, FIFO pops and output-register load selection
    always_comb begin
        state_d        = state_q;
        drop_d         = drop_q;
        fst_half_rd_en = 1'b0;
        snd_half_rd_en = 1'b0;
        seg_fifo_rd_en = 1'b0;
        load           = 1'b0;
        ld_tdata       = fst_half_tdata;
        ld_tuser       = fst_half_tuser;
        ld_tkeep       = fst_half_tkeep;
        ld_tlast       = fst_half_tlast;

        unique case (state_q)
            WAIT_FST: begin
                if (!fst_half_empty && (drop_fst_c || out_ok_c)) begin
                    if (fst_half_tlast) begin
                        // Single-segment packet: second half is a dummy, pop both together
                        if (!snd_half_empty) begin
                            fst_half_rd_en = 1'b1;
                            snd_half_rd_en = 1'b1;
                            load           = !drop_fst_c;
                            ld_tlast       = 1'b1;
                            drop_d         = 1'b0;
                        end
                    end else begin
                        fst_half_rd_en = 1'b1;
                        load           = !drop_fst_c;
                        drop_d         = drop_fst_c;
                        state_d        = EMIT_SND;
                    end
                end
            end

            EMIT_SND: begin
                if (!snd_half_empty && (drop_q || out_ok_c)) begin
                    snd_half_rd_en = 1'b1;
                    load           = !drop_q;
                    ld_tdata       = snd_half_tdata;
                    ld_tuser       = snd_half_tuser;
                    ld_tkeep       = snd_half_tkeep;
                    ld_tlast       = snd_half_tlast;
                    if (snd_half_tlast) begin
                        state_d = WAIT_FST;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = FLUSH_SEG;
                    end
                end
            end

            FLUSH_SEG: begin
                if (!seg_fifo_empty && (drop_q || out_ok_c)) begin
                    seg_fifo_rd_en = 1'b1;
                    load           = !drop_q;
                    ld_tdata       = seg_fifo_tdata;
                    ld_tuser       = seg_fifo_tuser;
                    ld_tkeep       = seg_fifo_tkeep;
                    ld_tlast       = seg_fifo_tlast;
                    if (seg_fifo_tlast) begin
                        state_d = WAIT_FST;
                        drop_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = WAIT_FST;
                drop_d  = 1'b0;
            end
        endcase
    end

    depar_axis_out_reg #(
        .DATA_W (C_AXIS_DATA_WIDTH),
        .USER_W (C_AXIS_TUSER_WIDTH)
    ) u_out_reg (
        .clk           (clk),
        .aresetn       (aresetn),
        .load          (load),
        .load_tdata    (ld_tdata),
        .load_tuser    (ld_tuser),
        .load_tkeep    (ld_tkeep),
        .load_tlast    (ld_tlast),
        .out_ok_c      (out_ok_c),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

endmodule

// File: tb/tb_depar_seg_merge.sv
// Bench for depar_seg_merge: FIFO models feed packets, a packet-level model
// predicts the output beat stream, and every cycle is checked against it.
// Build with DEPAR_SEG_MERGE_DROP_EN defined to exercise packet discard.
module tb_depar_seg_merge;
    import depar_pkg::*;

    logic clk = 1'b0;
    logic aresetn;
    logic tready;

    seg_t fh, sh, gh;
    logic fe, se, ge;
    logic fr, sr, gr;

    logic [AXIS_DW-1:0] m_tdata;
    logic [AXIS_UW-1:0] m_tuser;
    logic [AXIS_KW-1:0] m_tkeep;
    logic               m_tlast;
    logic               m_tvalid;

    seg_t fq[$], sq[$], gq[$];
    seg_t exp_q[$];
    int   hs_cyc[$];
    logic hide_f, hide_s, hide_g;
    logic pf, ps, pg;
    logic hold_pending;
    seg_t held;
    int   checks, errors, cyc, pops;

    always #5 clk = ~clk;

    depar_seg_merge dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .fst_half_tdata (fh.tdata),
        .fst_half_tuser (fh.tuser),
        .fst_half_tkeep (fh.tkeep),
        .fst_half_tlast (fh.tlast),
        .fst_half_empty (fe),
        .fst_half_rd_en (fr),
        .snd_half_tdata (sh.tdata),
        .snd_half_tuser (sh.tuser),
        .snd_half_tkeep (sh.tkeep),
        .snd_half_tlast (sh.tlast),
        .snd_half_empty (se),
        .snd_half_rd_en (sr),
        .seg_fifo_tdata (gh.tdata),
        .seg_fifo_tuser (gh.tuser),
        .seg_fifo_tkeep (gh.tkeep),
        .seg_fifo_tlast (gh.tlast),
        .seg_fifo_empty (ge),
        .seg_fifo_rd_en (gr),
        .m_axis_tdata   (m_tdata),
        .m_axis_tuser   (m_tuser),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tlast   (m_tlast),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (tready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic seg_t rand_seg();
        seg_t s;
        for (int i = 0; i < AXIS_DW / 32; i++) s.tdata[i*32 +: 32] = $urandom();
        for (int i = 0; i < AXIS_UW / 32; i++) s.tuser[i*32 +: 32] = $urandom();
        s.tkeep = {$urandom(), $urandom()};
        s.tlast = 1'($urandom_range(0, 1));
        return s;
    endfunction

    function automatic bit model_emits(input logic drop);
`ifdef DEPAR_SEG_MERGE_DROP_EN
        return !drop;
`else
        return (drop == drop);
`endif
    endfunction

    task automatic drive_heads();
        fe = (fq.size() == 0) || hide_f;
        se = (sq.size() == 0) || hide_s;
        ge = (gq.size() == 0) || hide_g;
        fh = (fq.size() != 0) ? fq[0] : '0;
        sh = (sq.size() != 0) ? sq[0] : '0;
        gh = (gq.size() != 0) ? gq[0] : '0;
    endtask

    // Split an n-segment packet across the three FIFOs and predict its output
    task automatic push_packet(input int n, input logic drop, input logic [31:0] tag);
        seg_t s;
        for (int i = 0; i < n; i++) begin
            s = rand_seg();
            s.tdata[31:0] = tag + 32'(i);
            s.tlast = (i == n - 1);
            if (i == 0) begin
                s.tuser[DROP_BIT_DFLT] = drop;
                fq.push_back(s);
                if (n == 1) sq.push_back(rand_seg());
            end else if (i == 1) begin
                sq.push_back(s);
            end else begin
                gq.push_back(s);
            end
            if (model_emits(drop)) exp_q.push_back(s);
        end
        drive_heads();
        #1;
    endtask

    // Per-cycle checks, sampled mid-cycle before the next active edge
    task automatic check_cycle();
        seg_t cur;
        seg_t e;
        cur = '{tdata: m_tdata, tuser: m_tuser, tkeep: m_tkeep, tlast: m_tlast};
        checks++;
        if ((fr && fe) || (sr && se) || (gr && ge)) begin
            errors++;
            $display("FAIL pop_while_empty rd=%b%b%b empty=%b%b%b (cycle %0d)", fr, sr, gr, fe, se, ge, cyc);
        end
        checks++;
        if ((gr && (fr || sr)) || (fr && sr && !fh.tlast)) begin
            errors++;
            $display("FAIL multi_pop rd=%b%b%b fst_tlast=%b (cycle %0d)", fr, sr, gr, fh.tlast, cyc);
        end
        if (aresetn) begin
            if (hold_pending) begin
                checks++;
                if (!m_tvalid || cur !== held) begin
                    errors++;
                    $display("FAIL hold_stable valid=%b data=%0h req=%0h (cycle %0d)", m_tvalid, cur.tdata[63:0], held.tdata[63:0], cyc);
                end
            end
            if (m_tvalid && tready) begin
                checks++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected data=%0h last=%b (cycle %0d)", cur.tdata[63:0], cur.tlast, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cur !== e) begin
                        errors++;
                        $display("FAIL beat_stream data=%0h last=%b user=%0h keep=%0h req data=%0h last=%b user=%0h keep=%0h (cycle %0d)",
                                 cur.tdata[63:0], cur.tlast, cur.tuser[63:0], cur.tkeep,
                                 e.tdata[63:0], e.tlast, e.tuser[63:0], e.tkeep, cyc);
                    end
                end
            end
            hold_pending = m_tvalid && !tready;
            held         = cur;
        end else begin
            hold_pending = 1'b0;
        end
        pf = fr;
        ps = sr;
        pg = gr;
        pops += int'(fr) + int'(sr) + int'(gr);
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        if (pf && fq.size() != 0) void'(fq.pop_front());
        if (ps && sq.size() != 0) void'(sq.pop_front());
        if (pg && gq.size() != 0) void'(gq.pop_front());
        cyc++;
        drive_heads();
        #1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fq.size() != 0 || sq.size() != 0 || gq.size() != 0 || m_tvalid) && n < budget) begin
            step();
            n++;
        end
        chk({name, "_drain_timeout"}, 64'(n >= budget), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [31:0] tag;
        checks = 0; errors = 0; cyc = 0; pops = 0;
        hide_f = 1'b0; hide_s = 1'b0; hide_g = 1'b0;
        hold_pending = 1'b0;
        pf = 1'b0; ps = 1'b0; pg = 1'b0;
        aresetn = 1'b0;
        tready  = 1'b0;
        drive_heads();
        repeat (3) step();
        aresetn = 1'b1;
        step();

        // Reset state
        chk("rst_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_tdata",  m_tdata[63:0], 64'd0);
        chk("rst_tlast",  64'(m_tlast), 64'd0);
        chk("rst_tkeep",  m_tkeep, 64'd0);
        chk("rst_rd_en",  64'({fr, sr, gr}), 64'd0);

        // Single-segment packet: pair pop, one beat with tlast
        tready = 1'b1;
        push_packet(1, 1'b0, 32'hA1);
        chk("seg1_pops", 64'({fr, sr, gr}), 64'b110);
        step();
        chk("seg1_valid", 64'(m_tvalid), 64'd1);
        chk("seg1_data",  64'(m_tdata[31:0]), 64'hA1);
        chk("seg1_last",  64'(m_tlast), 64'd1);
        drain("seg1", 20);

        // Two-segment packet on consecutive cycles
        push_packet(2, 1'b0, 32'hB0);
        chk("seg2_pop_fst", 64'({fr, sr, gr}), 64'b100);
        step();
        chk("seg2_a_data", 64'(m_tdata[31:0]), 64'hB0);
        chk("seg2_a_last", 64'(m_tlast), 64'd0);
        chk("seg2_pop_snd", 64'({fr, sr, gr}), 64'b010);
        step();
        chk("seg2_b_valid", 64'(m_tvalid), 64'd1);
        chk("seg2_b_data",  64'(m_tdata[31:0]), 64'hB1);
        chk("seg2_b_last",  64'(m_tlast), 64'd1);
        drain("seg2", 20);

        // Five segments with tready toggling
        base = hs_cyc.size();
        pops = 0;
        push_packet(5, 1'b0, 32'hC0);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            tready = ~tready;
            step();
        end
        tready = 1'b1;
        drain("seg5", 20);
        chk("seg5_pops",  64'(pops), 64'd5);
        chk("seg5_beats", 64'(hs_cyc.size() - base), 64'd5);

        // Three segments with a late third segment, then a single-segment packet
        hide_g = 1'b1;
        push_packet(3, 1'b0, 32'hD0);
        push_packet(1, 1'b0, 32'hE0);
        repeat (6) step();
        chk("stall_pending", 64'(exp_q.size()), 64'd2);
        hide_g = 1'b0;
        drive_heads();
        drain("stall", 20);
        chk("no_gap_after_c", 64'(hs_cyc[hs_cyc.size()-1] - hs_cyc[hs_cyc.size()-2]), 64'd1);

        // Reset after the second beat of a four-segment packet
        base = hs_cyc.size();
        push_packet(4, 1'b0, 32'hF0);
        for (int i = 0; i < 10 && hs_cyc.size() < base + 2; i++) step();
        aresetn = 1'b0;
        tready  = 1'b0;
        fq.delete(); sq.delete(); gq.delete(); exp_q.delete();
        drive_heads();
        step();
        chk("mid_rst_tvalid", 64'(m_tvalid), 64'd0);
        aresetn = 1'b1;
        tready  = 1'b1;
        step();
        push_packet(2, 1'b0, 32'h50);
        chk("post_rst_pop_fst", 64'({fr, sr, gr}), 64'b100);
        drain("post_rst", 20);

`ifdef DEPAR_SEG_MERGE_DROP_EN
        // Dropped packet drains under backpressure without any output
        tready = 1'b0;
        pops = 0;
        push_packet(3, 1'b1, 32'h60);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drop_no_valid", 64'(m_tvalid), 64'd0);
        end
        chk("drop_pops", 64'(pops), 64'd3);
        chk("drop_fifos_empty", 64'(fq.size() + sq.size() + gq.size()), 64'd0);
        tready = 1'b1;
        push_packet(2, 1'b0, 32'h70);
        drain("after_drop", 20);
`endif

        // Randomized packets, stalls and backpressure
        tag = 32'h1000;
        for (int c = 0; c < 4000; c++) begin
            if (fq.size() < 3 && $urandom_range(0, 2) == 0) begin
                push_packet($urandom_range(1, 6), 1'($urandom_range(0, 3) == 0), tag);
                tag += 32'h10;
            end
            tready = ($urandom_range(0, 3) != 0);
            hide_f = ($urandom_range(0, 4) == 0);
            hide_s = ($urandom_range(0, 4) == 0);
            hide_g = ($urandom_range(0, 4) == 0);
            drive_heads();
            step();
        end
        tready = 1'b1;
        hide_f = 1'b0; hide_s = 1'b0; hide_g = 1'b0;
        drive_heads();
        drain("random", 2000);
        chk("final_expected_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
